// File: rtl/ka_pkg.sv
// Shared definitions for the sequential Karatsuba GF(2)[x] multiplier.
//   state_t : FSM encoding (IDLE -> MUL_LO -> MUL_HI -> MUL_MID -> DONE)
//   half_w  : width of the sub-multiplier operands for a given operand width
package ka_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL_LO  = 3'd1,
        MUL_HI  = 3'd2,
        MUL_MID = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Odd widths round up; the high half then carries one zero pad bit.
    function automatic int half_w(input int width);
        return (width + 1) / 2;
    endfunction

endpackage

// File: rtl/gf2_clmul_comb.sv
// Combinational carry-less (GF(2)[x]) multiplier, W x W -> 2W-1 bits.
//   a : operand, bit i = coefficient of x^i
//   b : operand
//   p : polynomial product a*b over GF(2)
// Plain AND/XOR array: each set bit of b contributes a shifted copy of a.
module gf2_clmul_comb #(
    parameter int W = 52
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-2:0] p
);

    localparam int PW = 2 * W - 1;

    always_comb begin
        p = '0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) begin
                p = p ^ (PW'(a) << i);
            end
        end
    end

endmodule

// File: rtl/ka_gf2_mult_seq.sv
// Sequential one-level Karatsuba carry-less multiplier with optional
// XOR-accumulate. A single half-width multiplier is reused for the low,
// high and middle partial products over three consecutive cycles.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   in_valid   : operands a, b and acc_en are valid
//   in_ready   : block accepts operands on this edge if in_valid is high
//   a, b       : WIDTH-bit operands, bit i = coefficient of x^i
//   acc_en     : 1 -> y = a*b ^ previous y, 0 -> y = a*b
//   out_valid  : y holds a finished result
//   out_ready  : consumer takes y on this edge if out_valid is high
//   y          : 2*WIDTH-1 bit product (optionally accumulated)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The source keeps valid and its data stable until that edge;
// ready never depends on the same side's valid. While out_valid is high and
// out_ready low, y and out_valid are frozen and no new operand is taken.
module ka_gf2_mult_seq
    import ka_pkg::*;
#(
    parameter int WIDTH = 103
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               acc_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-2:0] y
);

    localparam int HALF = half_w(WIDTH);
    localparam int PW   = 2 * HALF - 1;
    localparam int YW   = 2 * WIDTH - 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             acc_q, acc_d;
    logic [PW-1:0]    p0_q, p0_d;
    logic [PW-1:0]    p2_q, p2_d;
    logic [YW-1:0]    y_q, y_d;
    logic             out_valid_q, out_valid_d;

    logic [HALF-1:0]  a_lo, a_hi, a_mid;
    logic [HALF-1:0]  b_lo, b_hi, b_mid;
    logic [HALF-1:0]  mul_a, mul_b;
    logic [PW-1:0]    mul_p;
    logic [PW-1:0]    mid_term;
    logic [YW-1:0]    combined;
    logic             accept;

    // Operand halves. The size cast on the right shift zero-pads the high
    // half when WIDTH is odd.
    assign a_lo  = a_q[HALF-1:0];
    assign b_lo  = b_q[HALF-1:0];
    assign a_hi  = HALF'(a_q >> HALF);
    assign b_hi  = HALF'(b_q >> HALF);
    assign a_mid = a_lo ^ a_hi;
    assign b_mid = b_lo ^ b_hi;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign y         = y_q;

    // The shared sub-multiplier sees whichever operand pair the current
    // state is working on.
    always_comb begin
        mul_a = a_lo;
        mul_b = b_lo;
        case (state_q)
            MUL_HI: begin
                mul_a = a_hi;
                mul_b = b_hi;
            end
            MUL_MID: begin
                mul_a = a_mid;
                mul_b = b_mid;
            end
            default: begin
                mul_a = a_lo;
                mul_b = b_lo;
            end
        endcase
    end

    gf2_clmul_comb #(
        .W (HALF)
    ) u_clmul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    // Karatsuba combine: P1 ^ P0 ^ P2 is the cross term aL*bH ^ aH*bL.
    // For odd WIDTH the top terms extend past YW bits; those bits are zero
    // because the padded high halves carry no coefficient there.
    always_comb begin
        mid_term = p0_q ^ mul_p ^ p2_q;
        combined = YW'(p0_q) ^ (YW'(mid_term) << HALF) ^ (YW'(p2_q) << (2 * HALF));
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        p0_d        = p0_q;
        p2_d        = p2_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = acc_en;
                    state_d = MUL_LO;
                end
            end
            MUL_LO: begin
                p0_d    = mul_p;
                state_d = MUL_HI;
            end
            MUL_HI: begin
                p2_d    = mul_p;
                state_d = MUL_MID;
            end
            MUL_MID: begin
                y_d         = combined ^ (acc_q ? y_q : '0);
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        // Back-to-back: result handed off and next operands
                        // taken on the same edge.
                        a_d     = a;
                        b_d     = b;
                        acc_d   = acc_en;
                        state_d = MUL_LO;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= 1'b0;
            p0_q        <= '0;
            p2_q        <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            p0_q        <= p0_d;
            p2_q        <= p2_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_ka_gf2_mult_seq.sv
// Self-checking bench for ka_gf2_mult_seq (WIDTH=103, plus WIDTH=8 and
// WIDTH=2 instances). Expected products come from a shift-and-XOR
// reference model and travel through an expected-value queue.
module tb_ka_gf2_mult_seq;

    localparam int W  = 103;
    localparam int YW = 2 * W - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main DUT
    logic          in_valid, in_ready, acc_en, out_valid, out_ready;
    logic [W-1:0]  a, b;
    logic [YW-1:0] y;

    // Small-width DUTs
    logic          s_out_ready;
    logic          s8_in_valid, s8_in_ready, s8_acc_en, s8_out_valid;
    logic [7:0]    s8_a, s8_b;
    logic [14:0]   s8_y;
    logic          s2_in_valid, s2_in_ready, s2_acc_en, s2_out_valid;
    logic [1:0]    s2_a, s2_b;
    logic [2:0]    s2_y;

    int            checks = 0;
    int            errors = 0;
    logic [YW-1:0] exp_q[$];
    logic [YW-1:0] model_y = '0;
    int            last_acc_cyc = 0;

    ka_gf2_mult_seq #(.WIDTH(W)) u_dut (
        .clk (clk), .rst_n (rst_n),
        .in_valid (in_valid), .in_ready (in_ready),
        .a (a), .b (b), .acc_en (acc_en),
        .out_valid (out_valid), .out_ready (out_ready), .y (y)
    );

    ka_gf2_mult_seq #(.WIDTH(8)) u_dut8 (
        .clk (clk), .rst_n (rst_n),
        .in_valid (s8_in_valid), .in_ready (s8_in_ready),
        .a (s8_a), .b (s8_b), .acc_en (s8_acc_en),
        .out_valid (s8_out_valid), .out_ready (s_out_ready), .y (s8_y)
    );

    ka_gf2_mult_seq #(.WIDTH(2)) u_dut2 (
        .clk (clk), .rst_n (rst_n),
        .in_valid (s2_in_valid), .in_ready (s2_in_ready),
        .a (s2_a), .b (s2_b), .acc_en (s2_acc_en),
        .out_valid (s2_out_valid), .out_ready (s_out_ready), .y (s2_y)
    );

    // Reference carry-less product, schoolbook shift-and-XOR.
    function automatic logic [YW-1:0] clmul_ref(input logic [W-1:0] x, input logic [W-1:0] z);
        logic [YW-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (z[i]) r = r ^ (YW'(x) << i);
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // Entered and left 1 time unit after a rising edge. in_ready is read
    // 2 units after the edge so a concurrent consumer has already set out_ready.
    task automatic drive_op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                            input logic acc, input string tag);
        int n = 0;
        logic [YW-1:0] e;
        in_valid = 1'b1;
        a        = aa;
        b        = bb;
        acc_en   = acc;
        #1;
        while (!in_ready && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: in_ready=0 after %0d cycles, required 1", tag, n);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        @(posedge clk);
        e       = clmul_ref(aa, bb) ^ (acc ? model_y : '0);
        model_y = e;
        exp_q.push_back(e);
        #1;
        last_acc_cyc = cyc;
        in_valid     = 1'b0;
    endtask

    // Waits (bounded) for out_valid with out_ready held high; returns y and
    // the number of edges waited, then steps past the handshake edge.
    task automatic get_result(output logic [YW-1:0] got, output int n_cyc, output bit ok);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        ok    = out_valid;
        got   = y;
        n_cyc = n;
        if (ok) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; acc_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || y !== '0) begin
            errors++;
            $display("FAIL reset_outputs: out_valid=%b y=%0h, required 0 and 0", out_valid, y);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== '0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b y=%0h, required 1 0 0",
                     in_ready, out_valid, y);
        end
    endtask

    task automatic test_single();
        logic [YW-1:0] got, e;
        int n;
        bit ok;
        out_ready = 1'b1;
        drive_op(W'(1), W'(1), 1'b0, "single");
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_busy: in_ready=%b while computing, required 0", in_ready);
        end
        get_result(got, n, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || n !== 3) begin
            errors++;
            $display("FAIL single_latency: out_valid after %0d edges (seen=%0b), required 3", n, ok);
        end
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL single_y: got %0h, required %0h", got, e);
        end
    endtask

    task automatic test_top_bit();
        logic [YW-1:0] got, e;
        logic [W-1:0] top;
        int n;
        bit ok;
        top = '0;
        top[W-1] = 1'b1;
        drive_op(top, top, 1'b0, "top_bit");
        get_result(got, n, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || got !== e) begin
            errors++;
            $display("FAIL top_bit_y: got %0h (seen=%0b), required %0h", got, ok, e);
        end
    endtask

    task automatic test_accumulate();
        logic [YW-1:0] got, e;
        int n;
        bit ok;
        logic [W-1:0] ta[3];
        logic [W-1:0] tb[3];
        logic         tacc[3];
        ta = '{W'(3), W'(3), W'(1)};
        tb = '{W'(3), W'(3), W'(2)};
        tacc = '{1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 3; k++) begin
            drive_op(ta[k], tb[k], tacc[k], "accumulate");
            get_result(got, n, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || got !== e) begin
                errors++;
                $display("FAIL accumulate_%0d: got %0h (seen=%0b), required %0h", k, got, ok, e);
            end
        end
    endtask

    task automatic test_random(input int n_ops);
        int received = 0;
        fork
            begin
                logic [127:0] ra, rb;
                for (int k = 0; k < n_ops; k++) begin
                    ra = {$urandom, $urandom, $urandom, $urandom};
                    rb = {$urandom, $urandom, $urandom, $urandom};
                    drive_op(ra[W-1:0], rb[W-1:0], 1'($urandom_range(0, 1)), "random");
                end
            end
            begin
                bit stalled = 1'b0;
                logic [YW-1:0] held = '0;
                logic [YW-1:0] e;
                int idle = 0;
                while (received < n_ops && idle < 200) begin
                    @(posedge clk);
                    #1;
                    if (stalled) begin
                        checks++;
                        if (out_valid !== 1'b1 || y !== held || in_ready !== 1'b0) begin
                            errors++;
                            $display("FAIL random_stall: out_valid=%b in_ready=%b y=%0h, required 1 0 %0h",
                                     out_valid, in_ready, y, held);
                        end
                    end
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid) begin
                        idle = 0;
                        if (out_ready) begin
                            stalled = 1'b0;
                            received++;
                            checks++;
                            if (exp_q.size() == 0) begin
                                errors++;
                                $display("FAIL random_extra: got %0h, required no output", y);
                            end else begin
                                e = exp_q.pop_front();
                                if (y !== e) begin
                                    errors++;
                                    $display("FAIL random_y: got %0h, required %0h", y, e);
                                end
                            end
                        end else begin
                            stalled = 1'b1;
                            held    = y;
                        end
                    end else begin
                        stalled = 1'b0;
                        idle++;
                    end
                end
            end
        join
        out_ready = 1'b1;
        checks++;
        if (received != n_ops || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_count: received %0d with %0d pending, required %0d and 0",
                     received, exp_q.size(), n_ops);
        end
    endtask

    task automatic test_back_to_back();
        int acc_times[$];
        int received = 0;
        out_ready = 1'b1;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    drive_op(W'(k + 5), W'(3 * k + 7), 1'b0, "b2b");
                    acc_times.push_back(last_acc_cyc);
                end
            end
            begin
                int idle = 0;
                logic [YW-1:0] e;
                while (received < 6 && idle < 50) begin
                    @(posedge clk);
                    #1;
                    if (out_valid) begin
                        idle = 0;
                        received++;
                        e = exp_q.pop_front();
                        checks++;
                        if (y !== e) begin
                            errors++;
                            $display("FAIL b2b_y: got %0h, required %0h", y, e);
                        end
                    end else begin
                        idle++;
                    end
                end
            end
        join
        checks++;
        if (received != 6) begin
            errors++;
            $display("FAIL b2b_count: received %0d, required 6", received);
        end
        for (int k = 1; k < acc_times.size(); k++) begin
            checks++;
            if (acc_times[k] - acc_times[k-1] != 4) begin
                errors++;
                $display("FAIL b2b_interval: %0d cycles between accepts, required 4",
                         acc_times[k] - acc_times[k-1]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_op();
        logic [YW-1:0] got, e;
        int n;
        bit ok;
        bit spurious = 1'b0;
        out_ready = 1'b1;
        // Leave a non-zero y behind so the reset clear is observable.
        drive_op(W'(7), W'(9), 1'b0, "rst_pre");
        get_result(got, n, ok);
        void'(exp_q.pop_front());
        drive_op(W'(11), W'(13), 1'b0, "rst_abort");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || y !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_op: out_valid=%b y=%0h in_ready=%b, required 0 0 1",
                     out_valid, y, in_ready);
        end
        exp_q.delete();
        model_y = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) spurious = 1'b1;
        end
        checks++;
        if (spurious) begin
            errors++;
            $display("FAIL rst_no_partial: out_valid=1 after abort, required 0");
        end
        drive_op(W'(5), W'(3), 1'b1, "rst_post");
        get_result(got, n, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || n !== 3 || got !== e) begin
            errors++;
            $display("FAIL rst_post_op: got %0h after %0d edges, required %0h after 3", got, n, e);
        end
    endtask

    task automatic test_small_widths();
        logic [YW-1:0] full;
        logic [14:0]   e8, m8;
        logic [2:0]    e2, m2;
        int n;
        m8 = '0;
        m2 = '0;
        s_out_ready = 1'b1;
        for (int k = 0; k < 32; k++) begin
            s8_a = (k == 0) ? 8'h80 : ((k == 1) ? 8'h01 : 8'($urandom));
            s8_b = (k == 0) ? 8'h80 : ((k == 1) ? 8'h01 : 8'($urandom));
            s8_acc_en = (k >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            s2_a = k[1:0];
            s2_b = k[3:2];
            s2_acc_en = k[4];
            full = clmul_ref(W'(s8_a), W'(s8_b));
            e8   = full[14:0] ^ (s8_acc_en ? m8 : '0);
            m8   = e8;
            full = clmul_ref(W'(s2_a), W'(s2_b));
            e2   = full[2:0] ^ (s2_acc_en ? m2 : '0);
            m2   = e2;
            s8_in_valid = 1'b1;
            s2_in_valid = 1'b1;
            @(posedge clk);
            #1;
            s8_in_valid = 1'b0;
            s2_in_valid = 1'b0;
            n = 0;
            while (!(s8_out_valid && s2_out_valid) && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            checks++;
            if (!s8_out_valid || n !== 3 || s8_y !== e8) begin
                errors++;
                $display("FAIL w8_y: got %0h after %0d edges, required %0h after 3", s8_y, n, e8);
            end
            checks++;
            if (!s2_out_valid || s2_y !== e2) begin
                errors++;
                $display("FAIL w2_y: got %0h (valid=%b), required %0h", s2_y, s2_out_valid, e2);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- sequencing and report ----------------
    initial begin
        s_out_ready = 1'b1;
        s8_in_valid = 1'b0; s8_a = '0; s8_b = '0; s8_acc_en = 1'b0;
        s2_in_valid = 1'b0; s2_a = '0; s2_b = '0; s2_acc_en = 1'b0;
        test_reset();
        test_single();
        test_top_bit();
        test_accumulate();
        test_random(1000);
        test_back_to_back();
        test_reset_mid_op();
        test_small_widths();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
